// File: rtl/rr_arb4_idx.sv
// Four-requester round-robin arbiter that produces a registered 2-bit grant index
// {a,b} plus gnt_valid. Define RR_ARB_STATS_EN to add the saturating grant_count output.
module rr_arb4_idx #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  output logic             a,
  output logic             b,
  output logic             gnt_valid
`ifdef RR_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_count
`endif
);

  // Handshake: {a,b} is meaningful only while gnt_valid=1 and reads as 00 otherwise.
  // Requesters keep req[i] high for as long as they want to own the grant.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit         HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

  // Illegal configurations leave a named, empty marker in the elaborated hierarchy.
  if (MAX_HOLD > 255 || CNT_W < 1) begin : g_bad_config
  end

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] ptr_q, ptr_d;
  logic       vld_q, vld_d;
  logic [7:0] hold_q, hold_d;

  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic [1:0] win_ofs;
  logic [1:0] win;
  logic [3:0] cur_mask;
  logic       any_req;
  logic       others;
  logic       at_limit;
  logic       new_grant;

  // Rotate the requests so that bit 0 is ptr; the first set bit is then the winner.
  always_comb begin
    req_dbl = {req, req};
    req_rot = 4'(req_dbl >> ptr_q);
    win_ofs = 2'd0;
    if (req_rot[0])      win_ofs = 2'd0;
    else if (req_rot[1]) win_ofs = 2'd1;
    else if (req_rot[2]) win_ofs = 2'd2;
    else if (req_rot[3]) win_ofs = 2'd3;
    win      = ptr_q + win_ofs;
    any_req  = |req;
    cur_mask = 4'b0001 << idx_q;
    others   = |(req & ~cur_mask);
    at_limit = HOLD_EN && (hold_q == HOLD_LAST);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    vld_d     = vld_q;
    hold_d    = hold_q;
    new_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) new_grant = 1'b1;
      end
      GRANT: begin
        if (!req[idx_q]) begin
          if (any_req) begin
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
            vld_d   = 1'b0;
            idx_d   = 2'd0;
          end
        end else if (at_limit) begin
          // ptr already points past the holder, so a preemption always picks someone else.
          if (others) new_grant = 1'b1;
          else        hold_d    = 8'd0;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        idx_d   = 2'd0;
      end
    endcase
    if (new_grant) begin
      state_d = GRANT;
      vld_d   = 1'b1;
      idx_d   = win;
      ptr_d   = win + 2'd1;
      hold_d  = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      ptr_q   <= 2'd0;
      vld_q   <= 1'b0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      hold_q  <= hold_d;
    end
  end

  assign a         = idx_q[1];
  assign b         = idx_q[0];
  assign gnt_valid = vld_q;

`ifdef RR_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (new_grant && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_rr_arb4_idx.sv
// Bench for rr_arb4_idx: one instance with MAX_HOLD=8 and one with MAX_HOLD=1 (CNT_W=4),
// both checked each cycle against a behavioural model through an expected-value queue.
module tb_rr_arb4_idx;

  logic       clk;
  logic       rst;
  logic [3:0] req0, req1;
  logic       a0, b0, v0;
  logic       a1, b1, v1;
`ifdef RR_ARB_STATS_EN
  logic [15:0] gc0;
  logic [3:0]  gc1;
`endif

  rr_arb4_idx #(.MAX_HOLD(8), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .a(a0), .b(b0), .gnt_valid(v0)
`ifdef RR_ARB_STATS_EN
    , .grant_count(gc0)
`endif
  );

  rr_arb4_idx #(.MAX_HOLD(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .a(a1), .b(b1), .gnt_valid(v1)
`ifdef RR_ARB_STATS_EN
    , .grant_count(gc1)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [5:0] exp_q[$];
  logic [3:0] exp_cnt_q[$];

  // behavioural model state, index 0 = u_dut0, index 1 = u_dut1
  bit m_vld[2];
  int m_idx[2];
  int m_ptr[2];
  int m_held[2];
  int m_cnt;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  task automatic model_step(input int i, input logic [3:0] r, input bit rs);
    int  mh;
    bit  grant_new;
    int  w;
    mh = (i == 0) ? 8 : 1;
    grant_new = 1'b0;
    if (rs) begin
      m_vld[i] = 1'b0; m_idx[i] = 0; m_ptr[i] = 0; m_held[i] = 0;
      if (i == 1) m_cnt = 0;
      return;
    end
    if (!m_vld[i]) begin
      grant_new = (r != 4'b0000);
    end else if (!r[m_idx[i]]) begin
      if (r != 4'b0000) grant_new = 1'b1;
      else begin
        m_vld[i] = 1'b0; m_idx[i] = 0;
      end
    end else if (mh != 0 && m_held[i] == mh) begin
      if ((r & ~(4'b0001 << m_idx[i])) != 4'b0000) grant_new = 1'b1;
      else m_held[i] = 1;
    end else begin
      m_held[i]++;
    end
    if (grant_new) begin
      w = pick(r, m_ptr[i]);
      m_idx[i] = w; m_vld[i] = 1'b1; m_ptr[i] = (w + 1) % 4; m_held[i] = 1;
      if (i == 1 && m_cnt < 15) m_cnt++;
    end
  endtask

  function automatic logic [2:0] obs0();
    return {v0, a0, b0};
  endfunction

  function automatic logic [2:0] obs1();
    return {v1, a1, b1};
  endfunction

  // driver: apply one cycle of stimulus, then compare against the popped expectation
  task automatic step(input logic [3:0] r0, input logic [3:0] r1, input bit rs);
    logic [5:0] e;
    logic [3:0] ec;
    req0 = r0; req1 = r1; rst = rs;
    model_step(0, r0, rs);
    model_step(1, r1, rs);
    exp_q.push_back({m_vld[0], 2'(m_idx[0]), m_vld[1], 2'(m_idx[1])});
    exp_cnt_q.push_back(4'(m_cnt));
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    ec = exp_cnt_q.pop_front();
    check("model_dut0", 16'(obs0()), 16'(e[5:3]));
    check("model_dut1", 16'(obs1()), 16'(e[2:0]));
`ifdef RR_ARB_STATS_EN
    check("model_cnt1", 16'(gc1), 16'(ec));
`else
    if (ec > 4'd15) $display("unexpected model count %0d", ec);
`endif
  endtask

  initial begin
    logic [3:0] seq_idx [5];
    logic [3:0] ra, rb;
    req0 = 4'b0000; req1 = 4'b0000; rst = 1'b1;
    @(negedge clk);

    // reset for two cycles
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
    check("reset_dut0", 16'(obs0()), 16'd0);
    check("reset_dut1", 16'(obs1()), 16'd0);

    // single request and release
    step(4'b0100, 4'b0000, 1'b0);
    check("single_grant", 16'(obs0()), 16'(3'b110));
    step(4'b0000, 4'b0000, 1'b0);
    check("single_release", 16'(obs0()), 16'(3'b000));

    // fairness under MAX_HOLD=1: 0,1,2,3,0
    seq_idx[0] = 0; seq_idx[1] = 1; seq_idx[2] = 2; seq_idx[3] = 3; seq_idx[4] = 0;
    for (int k = 0; k < 5; k++) begin
      step(4'b0000, 4'b1111, 1'b0);
      check("rr_seq", 16'(obs1()), 16'({1'b1, seq_idx[k][1:0]}));
    end
    step(4'b0000, 4'b0000, 1'b0);

    // hold for exactly 8 cycles, then preempt to index 1
    step(4'b0001, 4'b0000, 1'b0);
    check("hold_first", 16'(obs0()), 16'(3'b100));
    for (int k = 0; k < 7; k++) begin
      step(4'b0011, 4'b0000, 1'b0);
      check("hold_keep", 16'(obs0()), 16'(3'b100));
    end
    step(4'b0011, 4'b0000, 1'b0);
    check("hold_preempt", 16'(obs0()), 16'(3'b101));

    // lone requester keeps the grant indefinitely
    for (int k = 0; k < 20; k++) begin
      step(4'b0001, 4'b0000, 1'b0);
      check("hold_lone", 16'(obs0()), 16'(3'b100));
    end
    step(4'b0000, 4'b0000, 1'b0);

    // back-to-back release without a bubble
    step(4'b1100, 4'b0000, 1'b0);
    check("b2b_first", 16'(obs0()), 16'(3'b110));
    step(4'b1000, 4'b0000, 1'b0);
    check("b2b_next", 16'(obs0()), 16'(3'b111));

    // reset mid-grant, then ptr restarts at 0
    step(4'b1000, 4'b0000, 1'b1);
    check("rst_mid", 16'(obs0()), 16'(3'b000));
    step(4'b0000, 4'b0000, 1'b0);
    check("rst_idle", 16'(obs0()), 16'(3'b000));
    step(4'b1001, 4'b0000, 1'b0);
    check("rst_ptr0", 16'(obs0()), 16'(3'b100));

    // randomized traffic with occasional reset
    for (int k = 0; k < 300; k++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      step(ra, rb, ($urandom_range(0, 49) == 0));
    end

    // grant counter saturation on the MAX_HOLD=1 instance
    step(4'b0000, 4'b0000, 1'b1);
    for (int k = 0; k < 22; k++) step(4'b0000, 4'b1111, 1'b0);
`ifdef RR_ARB_STATS_EN
    check("cnt_sat", 16'(gc1), 16'd15);
    step(4'b0000, 4'b1111, 1'b0);
    check("cnt_hold", 16'(gc1), 16'd15);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
